pipe_addsub_unit: RTL
=====================

// Module: pipe_addsub_unit
// PURPOSE
//  Parametrised, pipelined add/subtract/absolute-difference unit with valid/ready handshakes.
//  It replaces the fixed 8-bit combinational a-b subtractor (9-bit diff) and adds:
//   - an operation select;
//   - a pipeline that can be stalled;
//   - a sign flag;
//   - a counter of completed transactions.
//  It sits between an operand producer and a result consumer in the arithmetic datapath.
// PARAMETERS
//  WIDTH  8   operand width in bits; result is WIDTH+1 bits
//  PIPE   2   pipeline stages (latency in cycles), legal 1..4
//  CNT_W  16  width of the completed-transaction counter
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands a, b, op are valid
//  in_ready   out  1        unit accepts operands this cycle
//  a          in   WIDTH    operand A, unsigned
//  b          in   WIDTH    operand B, unsigned
//  op         in   2        0=ADD, 1=SUB, 2=ABSDIFF, 3=reserved (treated as SUB)
//  out_valid  out  1        result, neg, ovf are valid
//  out_ready  in   1        consumer accepts result this cycle
//  result     out  WIDTH+1  arithmetic result
//  neg        out  1        SUB/ABSDIFF: 1 when a<b; ADD: 0
//  ovf        out  1        ADD: carry out (result[WIDTH]); SUB/ABSDIFF: 0
//  clear      in   1        synchronous clear of txn_cnt
//  txn_cnt    out  CNT_W    number of results handed off (out_valid & out_ready)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - all stage valids, out_valid, result, neg, ovf and txn_cnt go to 0;
//   - the pipeline contents are discarded;
//   - on release, the first accept can occur at the first rising edge.
//  Arithmetic (zero-extend a, b to WIDTH+1):
//   - ADD: a+b.
//   - SUB: a-b modulo 2^(WIDTH+1); result[WIDTH] equals neg.
//   - ABSDIFF: |a-b|; result[WIDTH] is always 0.
//   - The computation happens in stage 1. Later stages only register the result.
//  Pipeline and handshake:
//   - Pipeline enable is adv = ~out_valid | out_ready.
//   - in_ready = adv. There is no combinational path from in_valid to in_ready.
//   - When adv=1, every stage shifts. Stage 1 loads (in_valid, a, b, op).
//   - When adv=0, all stages hold.
//   - A transaction is accepted when in_valid & in_ready.
//   - With no stall, its result appears with out_valid=1 exactly PIPE cycles after acceptance.
//   - While out_valid & ~out_ready, result, neg and ovf stay stable.
//   - Bubbles (in_valid=0) propagate as invalid stages. They stall nothing.
//   - Back-to-back accepts give one result per cycle. Throughput is 1 when out_ready stays high.
//   - Order is preserved. There is no loss or duplication across any stall pattern.
//  Counter:
//   - txn_cnt increments on each out_valid & out_ready.
//   - It wraps from 2^CNT_W-1 to 0.
//   - clear=1 forces txn_cnt to 0 on the next edge. clear wins over a same-cycle handoff.
//   - clear does not affect the pipeline.
//  Boundary cases:
//   - a=b under SUB or ABSDIFF gives result=0 and neg=0.
//   - a=0, b=2^WIDTH-1 under SUB gives result = 2^(WIDTH+1) - (2^WIDTH-1), with neg=1.
//   - Reset asserted mid-stream drops in-flight results. txn_cnt does not count them.
//   - If out_ready rises in the same cycle a new accept occurs, the output and new input shift together.
// TESTING  (WIDTH=8, PIPE=2, CNT_W=16 unless stated)
//  1. ADD a=200 b=100, out_ready=1 -> 2 cycles later out_valid=1, result=300, ovf=1, neg=0.
//  2. SUB a=5 b=10 -> result=9'h1FB, neg=1. ABSDIFF a=5 b=10 -> result=5, neg=1.
//     SUB a=7 b=7 -> result=0, neg=0.
//  3. Stall: stream 4 ADDs (1+1, 2+2, 3+3, 4+4); hold out_ready=0 for 3 cycles after the first out_valid.
//     -> result holds at 2, in_ready=0 during the stall, then 2, 4, 6, 8 are delivered in order;
//     -> txn_cnt=4.
//  4. Random: 65536 random a, b, op with random out_ready (50%).
//     -> every result matches the reference model in order;
//     -> txn_cnt equals the handshake count mod 2^16.
//  5. Assert rst_n=0 with 2 results in flight -> out_valid=0 and txn_cnt=0 immediately;
//     after release, the next accept returns its result 2 cycles later.
//  6. CNT_W=4: 16 handoffs -> txn_cnt wraps to 0. clear asserted with a handoff in the same cycle -> txn_cnt=0.

Source files
------------

// File: rtl/pipe_addsub_unit.sv
// rtl/pipe_addsub_unit.sv - pipelined add/sub/absdiff unit with valid/ready handshakes
//
// Purpose:
//    Computes ADD, SUB or ABSDIFF on two unsigned WIDTH-bit operands in stage 1.
//    Stages 2..PIPE only carry the result forward. The whole pipeline advances
//    together when the output slot is empty or being taken. It also counts the
//    results handed off to the consumer.
//
// Ports:
//    clk        in   1        clock, rising edge
//    rst_n      in   1        asynchronous active-low reset
//    in_valid   in   1        a, b, op valid
//    in_ready   out  1        operands accepted this cycle (= pipeline advance)
//    a, b       in   WIDTH    unsigned operands
//    op         in   2        0=ADD 1=SUB 2=ABSDIFF 3=SUB
//    out_valid  out  1        result, neg, ovf valid
//    out_ready  in   1        consumer takes result this cycle
//    result     out  WIDTH+1  arithmetic result
//    neg        out  1        a<b for SUB/ABSDIFF, 0 for ADD
//    ovf        out  1        carry out for ADD, 0 otherwise
//    clear      in   1        synchronous clear of txn_cnt (wins over a handoff)
//    txn_cnt    out  CNT_W    completed handoffs, wrapping

module pipe_addsub_unit #(
   parameter int WIDTH = 8,
   parameter int PIPE  = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             neg,
   output logic             ovf,
   input  logic             clear,
   output logic [CNT_W-1:0] txn_cnt
);

   logic             adv;
   logic [WIDTH:0]   ae, be, sum, dif, mag;
   logic             lt;
   logic [WIDTH:0]   s_res;
   logic             s_neg, s_ovf;

   logic [PIPE-1:0]  v_q;
   logic [PIPE-1:0]  neg_q;
   logic [PIPE-1:0]  ovf_q;
   logic [WIDTH:0]   res_q [PIPE];

   // A single enable for every stage: the last stage is free or draining.
   // Depends only on registered out_valid and the consumer, never on in_valid.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Stage-1 arithmetic on zero-extended operands.
   always_comb begin
      ae    = {1'b0, a};
      be    = {1'b0, b};
      lt    = (a < b);
      sum   = ae + be;
      dif   = ae - be;
      mag   = lt ? (be - ae) : (ae - be);
      s_res = dif;
      s_neg = lt;
      s_ovf = 1'b0;
      case (op)
         2'd0: begin
            s_res = sum;
            s_neg = 1'b0;
            s_ovf = sum[WIDTH];
         end
         2'd2: s_res = mag;
         default: ;  // SUB and reserved code share the modular difference
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         neg_q <= '0;
         ovf_q <= '0;
         for (int i = 0; i < PIPE; i++) res_q[i] <= '0;
      end else if (adv) begin
         v_q[0]   <= in_valid;
         res_q[0] <= s_res;
         neg_q[0] <= s_neg;
         ovf_q[0] <= s_ovf;
         for (int i = 1; i < PIPE; i++) begin
            v_q[i]   <= v_q[i-1];
            res_q[i] <= res_q[i-1];
            neg_q[i] <= neg_q[i-1];
            ovf_q[i] <= ovf_q[i-1];
         end
      end
   end

   assign out_valid = v_q[PIPE-1];
   assign result    = res_q[PIPE-1];
   assign neg       = neg_q[PIPE-1];
   assign ovf       = ovf_q[PIPE-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         txn_cnt <= '0;
      else if (clear)
         txn_cnt <= '0;
      else if (out_valid && out_ready)
         txn_cnt <= txn_cnt + 1'b1;
   end

endmodule
